// File: rtl/mru_arb_pkg.sv
// rtl/mru_arb_pkg.sv - shared state encoding, op codes and defaults for the MRU access arbiter
package mru_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    GET_WAIT  = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic OP_GET = 1'b0;
  localparam logic OP_SET = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYC = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first valid requester after last_grant
module rr_arbiter
  import mru_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);

  localparam int ID_W = $clog2(NUM_REQ);

  int            cand;
  logic [ID_W-1:0] cand_idx;

  // scan requesters starting just after the previous winner, wrapping around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!grant_any && valid[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mru_access_arbiter.sv
// rtl/mru_access_arbiter.sv - round-robin sharing of one MRU buffer set/get port; MRU_ARB_TIMEOUT_EN adds a busy watchdog
module mru_access_arbiter
  import mru_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 16,
  parameter int BUF_SIZE    = 8,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_op_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [WIDTH-1:0]           rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       buf_en_o,
  output logic                       buf_set_o,
  output logic                       buf_get_o,
  output logic [WIDTH-1:0]           buf_data_o,
  input  logic                       buf_busy_i,
  input  logic [WIDTH-1:0]           buf_data_i
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int ADDR_W = $clog2(BUF_SIZE);
  localparam logic [WIDTH-1:0] IDX_MASK = {{(WIDTH-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] id_q;
  logic            op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rdata_q;
  logic            err_q;
  logic            timeout_hit;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               sel_op;
  logic [WIDTH-1:0]   sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid      (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // pick the winner's op and data word out of the packed request buses
  always_comb begin
    sel_op   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op   = req_op_i[i];
        sel_data = req_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MRU_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  // watchdog counts busy cycles while waiting; zero whenever outside WAIT_BUSY
  always_ff @(posedge clk) begin
    if (rst || state_q != WAIT_BUSY) wd_q <= '0;
    else if (buf_busy_i)             wd_q <= wd_q + 1'b1;
  end

  assign timeout_hit = (state_q == WAIT_BUSY) && buf_busy_i && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYC);
  assign timeout_hit    = 1'b0;
`endif

  // next-state sequencing of a single operation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_any) state_d = ISSUE;
      ISSUE:     state_d = (op_q == OP_SET) ? WAIT_BUSY : GET_WAIT;
      WAIT_BUSY: if (!buf_busy_i || timeout_hit) state_d = RESP;
      GET_WAIT:  state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // state register plus latched request, read data and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      op_q         <= OP_GET;
      data_q       <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_any) begin
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
        op_q         <= sel_op;
        data_q       <= (sel_op == OP_SET) ? sel_data : (sel_data & IDX_MASK);
        rdata_q      <= '0;
        err_q        <= 1'b0;
      end
      if (state_q == GET_WAIT) rdata_q <= buf_data_i;
      if (timeout_hit)         err_q   <= 1'b1;
    end
  end

  assign buf_en_o    = ~rst;
  assign req_ready_o = (!rst && state_q == IDLE) ? grant : '0;
  assign buf_set_o   = !rst && state_q == ISSUE && op_q == OP_SET;
  assign buf_get_o   = !rst && state_q == ISSUE && op_q == OP_GET;
  assign buf_data_o  = (state_q != IDLE) ? data_q : '0;
  assign rsp_valid_o = !rst && state_q == RESP;
  assign rsp_id_o    = rsp_valid_o ? id_q : '0;
  assign rsp_data_o  = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o & err_q;

endmodule

// File: tb/tb_mru_access_arbiter.sv
// tb/tb_mru_access_arbiter.sv - directed self-checking bench for mru_access_arbiter
module tb_mru_access_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_valid = '0;
  logic [3:0]  req_op = '0;
  logic [15:0] rd [4];
  logic [63:0] req_data;
  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  logic [3:0]  req_ready_o;
  logic        rsp_valid_o;
  logic [1:0]  rsp_id_o;
  logic [15:0] rsp_data_o;
  logic        rsp_err_o;
  logic        buf_en_o, buf_set_o, buf_get_o;
  logic [15:0] buf_data_o;
  logic        buf_busy;
  logic [15:0] buf_rdata = '0;

  mru_access_arbiter #(.NUM_REQ(4), .WIDTH(16), .BUF_SIZE(8), .TIMEOUT_CYC(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .buf_en_o    (buf_en_o),
    .buf_set_o   (buf_set_o),
    .buf_get_o   (buf_get_o),
    .buf_data_o  (buf_data_o),
    .buf_busy_i  (buf_busy),
    .buf_data_i  (buf_rdata)
  );

  logic [15:0] mem [8];
  int busy_len = 0;
  int busy_left = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)            busy_left <= 0;
    else if (buf_set_o) busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
    if (buf_get_o) buf_rdata <= mem[buf_data_o[2:0]];
  end
  assign buf_busy = (busy_left != 0);

  int n_checks = 0;
  int n_err = 0;
  int acc_id_q[$], acc_cyc_q[$];
  int rsp_id_q[$], rsp_data_q[$], rsp_err_q[$], rsp_cyc_q[$];
  int n_set = 0, n_get = 0, overlap = 0, multi_rdy = 0;
  logic [15:0] pulse_data = '0;
  logic [3:0]  rdy_seen = '0;
  int rearm_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    rdy_seen = req_ready_o;
    if (|req_ready_o) begin
      if ($countones(req_ready_o) != 1) multi_rdy++;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready_o[i]) acc_id_q.push_back(i);
      acc_cyc_q.push_back(cyc);
    end
    if (buf_set_o) begin n_set++; pulse_data = buf_data_o; end
    if (buf_get_o) begin n_get++; pulse_data = buf_data_o; end
    if (buf_set_o && buf_get_o) overlap++;
    if (rsp_valid_o) begin
      rsp_id_q.push_back(int'(rsp_id_o));
      rsp_data_q.push_back(int'(rsp_data_o));
      rsp_err_q.push_back(int'(rsp_err_o));
      rsp_cyc_q.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (rdy_seen[i]) begin
        if (rearm_left > 0) rearm_left--;
        else req_valid[i] = 1'b0;
      end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    acc_id_q.delete(); acc_cyc_q.delete();
    rsp_id_q.delete(); rsp_data_q.delete(); rsp_err_q.delete(); rsp_cyc_q.delete();
    n_set = 0; n_get = 0; overlap = 0; multi_rdy = 0;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rsp_id_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_done"}, rsp_id_q.size() >= n, 1);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_id [4];
  int exp_dat [4];

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    mem[3] = 16'h00AB;
    for (int i = 0; i < 4; i++) rd[i] = '0;

    // reset state
    step();
    step();
    @(negedge clk);
    chk("rst_en", buf_en_o, 0);
    chk("rst_quiet", {req_ready_o, buf_set_o, buf_get_o, rsp_valid_o, rsp_err_o}, 0);
    chk("rst_bufdata", buf_data_o, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_en", buf_en_o, 1);
    chk("idle_quiet", {req_ready_o, buf_set_o, buf_get_o, rsp_valid_o}, 0);

    // 1: req0 get index 3, upper data bits must be ignored
    clear_logs();
    step();
    rd[0] = 16'hFF03; req_op[0] = 1'b0; req_valid[0] = 1'b1;
    wait_rsp("t1", 1, 20);
    if (rsp_id_q.size() >= 1 && acc_id_q.size() >= 1) begin
      chk("t1_acc_id", acc_id_q[0], 0);
      chk("t1_rsp_id", rsp_id_q[0], 0);
      chk("t1_data", rsp_data_q[0], 16'h00AB);
      chk("t1_err", rsp_err_q[0], 0);
      chk("t1_latency", rsp_cyc_q[0] - acc_cyc_q[0], 3);
    end
    chk("t1_get_n", n_get, 1);
    chk("t1_set_n", n_set, 0);
    chk("t1_index", pulse_data, 16'h0003);

    // 2: req2 set with busy held 9 cycles
    clear_logs();
    busy_len = 9;
    rd[2] = 16'h1234; req_op[2] = 1'b1; req_valid[2] = 1'b1;
    wait_rsp("t2", 1, 40);
    if (rsp_id_q.size() >= 1 && acc_id_q.size() >= 1) begin
      chk("t2_acc_id", acc_id_q[0], 2);
      chk("t2_rsp_id", rsp_id_q[0], 2);
      chk("t2_data", rsp_data_q[0], 0);
      chk("t2_err", rsp_err_q[0], 0);
      chk("t2_latency", rsp_cyc_q[0] - acc_cyc_q[0], 12);
    end
    chk("t2_set_n", n_set, 1);
    chk("t2_get_n", n_get, 0);
    chk("t2_value", pulse_data, 16'h1234);

    // 3: all four valid straight out of reset
    rst = 1'b1;
    step();
    step();
    clear_logs();
    busy_len = 2;
    rd[0] = 16'h0001; req_op[0] = 1'b0;
    rd[1] = 16'h1111; req_op[1] = 1'b1;
    rd[2] = 16'h0002; req_op[2] = 1'b0;
    rd[3] = 16'h3333; req_op[3] = 1'b1;
    req_valid = 4'b1111;
    rst = 1'b0;
    wait_rsp("t3", 4, 80);
    exp_dat = '{16'h1001, 0, 16'h1002, 0};
    if (rsp_id_q.size() >= 4 && acc_id_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3_acc%0d", i), acc_id_q[i], i);
        chk($sformatf("t3_rsp_id%0d", i), rsp_id_q[i], i);
        chk($sformatf("t3_data%0d", i), rsp_data_q[i], exp_dat[i]);
      end
      chk("t3_first_lat", rsp_cyc_q[0] - acc_cyc_q[0], 3);
    end
    chk("t3_overlap", overlap, 0);
    chk("t3_multi_rdy", multi_rdy, 0);
    chk("t3_set_n", n_set, 2);
    chk("t3_get_n", n_get, 2);

    // 4: reset in the middle of WAIT_BUSY
    clear_logs();
    busy_len = 20;
    rd[1] = 16'h0055; req_op[1] = 1'b1; req_valid[1] = 1'b1;
    for (int k = 0; k < 10 && acc_id_q.size() < 1; k++) @(posedge clk);
    chk("t4_acc", acc_id_q.size(), 1);
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_same_cycle", {buf_set_o, buf_get_o, rsp_valid_o, buf_en_o, req_ready_o}, 0);
    step();
    @(negedge clk);
    chk("t4_outs_zero", {buf_data_o, rsp_data_o, rsp_id_o, rsp_err_o, buf_en_o}, 0);
    step();
    rst = 1'b0;
    repeat (15) step();
    chk("t4_no_rsp", rsp_id_q.size(), 0);
    clear_logs();
    busy_len = 0;
    rd[0] = 16'h0004; req_op[0] = 1'b0;
    rd[2] = 16'h0005; req_op[2] = 1'b0;
    req_valid = 4'b0101;
    wait_rsp("t4b", 2, 30);
    if (rsp_id_q.size() >= 2 && acc_id_q.size() >= 2) begin
      chk("t4_first_grant", acc_id_q[0], 0);
      chk("t4_second_grant", acc_id_q[1], 2);
      chk("t4_data0", rsp_data_q[0], 16'h1004);
      chk("t4_data1", rsp_data_q[1], 16'h1005);
    end

`ifdef MRU_ARB_TIMEOUT_EN
    // 5: busy stuck high until the watchdog fires
    clear_logs();
    busy_len = 100;
    rd[0] = 16'h0777; req_op[0] = 1'b1; req_valid[0] = 1'b1;
    wait_rsp("t5", 1, 60);
    if (rsp_id_q.size() >= 1 && acc_id_q.size() >= 1) begin
      chk("t5_err", rsp_err_q[0], 1);
      chk("t5_data", rsp_data_q[0], 0);
      chk("t5_id", rsp_id_q[0], 0);
      chk("t5_latency", rsp_cyc_q[0] - acc_cyc_q[0], 34);
    end
    do_reset();
`endif

    // 6: req1 and req3 continuously valid alternate
    do_reset();
    clear_logs();
    busy_len = 0;
    rearm_left = 2;
    rd[1] = 16'h0005; req_op[1] = 1'b0;
    rd[3] = 16'h0006; req_op[3] = 1'b0;
    req_valid = 4'b1010;
    wait_rsp("t6", 4, 40);
    exp_id  = '{1, 3, 1, 3};
    exp_dat = '{16'h1005, 16'h1006, 16'h1005, 16'h1006};
    if (rsp_id_q.size() >= 4 && acc_id_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t6_acc%0d", i), acc_id_q[i], exp_id[i]);
        chk($sformatf("t6_data%0d", i), rsp_data_q[i], exp_dat[i]);
      end
    end
    repeat (6) step();
    chk("t6_acc_n", acc_id_q.size(), 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
